// File: rtl/gearbox_pkg.sv
// Shared types and elaboration helpers for the FIFO gearbox.
// Width ratios are powers of two, so every ratio is derived from clog2.
package gearbox_pkg;

   typedef enum logic [1:0] {GB_EQUAL, GB_UP, GB_DOWN} gb_mode_e;

   function automatic int gb_ratio(input int in_w, input int out_w);
      if (out_w >= in_w) return 1 << ($clog2(out_w) - $clog2(in_w));
      return 1 << ($clog2(in_w) - $clog2(out_w));
   endfunction

   function automatic int gb_keep_w(input int in_w, input int out_w);
      return gb_ratio(in_w, out_w);
   endfunction

   function automatic gb_mode_e gb_mode(input int in_w, input int out_w);
      if (out_w > in_w) return GB_UP;
      if (in_w > out_w) return GB_DOWN;
      return GB_EQUAL;
   endfunction

   // Index of the highest set keep bit; an all-zero keep maps to lane 0.
   function automatic int keep_hi_lane(input logic [31:0] keep);
      int hi = 0;
      for (int i = 0; i < 32; i++) begin
         if (keep[i]) hi = i;
      end
      return hi;
   endfunction

endpackage

// File: rtl/gearbox_lane_ctrl.sv
// Lane/slice counter shared by the packer (write side) and unpacker (read side).
module gearbox_lane_ctrl
   import gearbox_pkg::*;
#(
   parameter int RATIO  = 4,
   parameter int LANE_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              step,
   input  logic              flush,
   input  logic [RATIO-1:0]  limit_keep,
   output logic [LANE_W-1:0] idx,
   output logic              at_end,
   output logic [RATIO-1:0]  keep_upto
);

   assign at_end = (int'(idx) == keep_hi_lane(32'(limit_keep)));

   always_ff @(posedge clk) begin
      if (rst) begin
         idx <= '0;
      end else if (step) begin
         idx <= (at_end || flush) ? '0 : idx + LANE_W'(1);
      end
   end

   always_comb begin
      keep_upto = '0;
      for (int i = 0; i < RATIO; i++) begin
         keep_upto[i] = (i <= int'(idx));
      end
   end

endmodule

// File: rtl/simple_fifo.sv
// First-word-fall-through FIFO with an occupancy count and a slack-adjusted full flag.
module simple_fifo #(
   parameter int WIDTH      = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int FULL_SLACK = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic                  pop,
   input  logic [WIDTH-1:0]      din,
   output logic [WIDTH-1:0]      dout,
   output logic                  empty,
   output logic                  full,
   output logic [ADDR_WIDTH:0]   count
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] FULL_AT = (ADDR_WIDTH + 1)'(DEPTH - FULL_SLACK);
   localparam logic [ADDR_WIDTH:0] CNT_MAX = (ADDR_WIDTH + 1)'(DEPTH);

   logic [WIDTH-1:0]      mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic                  do_push;
   logic                  do_pop;

   assign do_push = push && (count != CNT_MAX);
   assign do_pop  = pop && (count != '0);
   assign dout    = mem[rd_ptr];
   assign empty   = (count == '0);
   assign full    = (count >= FULL_AT);

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
         if (do_pop)  rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (ADDR_WIDTH + 1)'(1);
            2'b01:   count <= count - (ADDR_WIDTH + 1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/simple_fifo_gearbox.sv
// FWFT FIFO with power-of-two width conversion: N:1 packer in front of the
// storage when widening, 1:N unpacker behind it when narrowing.
module simple_fifo_gearbox
   import gearbox_pkg::*;
#(
   parameter int DATA_IN_WIDTH  = 16,
   parameter int DATA_OUT_WIDTH = 128,
   parameter int ADDR_WIDTH     = 8,
   parameter int FULL_SLACK     = 1,
   parameter int USE_LAST       = 1,
   localparam int KEEP_W        = gb_keep_w(DATA_IN_WIDTH, DATA_OUT_WIDTH)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wr_ena,
   input  logic [DATA_IN_WIDTH-1:0]  wr_dat,
   input  logic                      wr_last,
   input  logic [KEEP_W-1:0]         wr_keep,
   output logic                      wr_full,
   output logic                      wr_ovf,
   input  logic                      rd_ena,
   output logic [DATA_OUT_WIDTH-1:0] rd_dat,
   output logic [KEEP_W-1:0]         rd_keep,
   output logic                      rd_last,
   output logic                      rd_empty,
   output logic [ADDR_WIDTH:0]       rd_dat_cnt
);

   localparam int       RATIO  = gb_ratio(DATA_IN_WIDTH, DATA_OUT_WIDTH);
   localparam gb_mode_e MODE   = gb_mode(DATA_IN_WIDTH, DATA_OUT_WIDTH);
   localparam int       WIDE_W = (DATA_IN_WIDTH > DATA_OUT_WIDTH) ? DATA_IN_WIDTH : DATA_OUT_WIDTH;
   localparam int       FIFO_W = WIDE_W + KEEP_W + 1;
   localparam int       LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;

   if (FULL_SLACK < 1) begin : g_bad_slack
      $error("simple_fifo_gearbox: FULL_SLACK must be at least 1");
   end

   logic              wr_acc;
   logic              last_in;
   logic              fifo_push;
   logic              fifo_pop;
   logic              fifo_empty;
   logic              fifo_full;
   logic [FIFO_W-1:0] fifo_din;
   logic [FIFO_W-1:0] fifo_dout;
   logic [WIDE_W-1:0] head_dat;
   logic [KEEP_W-1:0] head_keep;
   logic              head_last;

   assign wr_acc   = wr_ena && !fifo_full;
   assign last_in  = (USE_LAST != 0) && wr_last;
   assign {head_last, head_keep, head_dat} = fifo_dout;
   assign wr_full  = fifo_full;
   assign rd_empty = fifo_empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ovf <= 1'b0;
      end else if (wr_ena && fifo_full) begin
         wr_ovf <= 1'b1;
      end
   end

   simple_fifo #(
      .WIDTH      (FIFO_W),
      .ADDR_WIDTH (ADDR_WIDTH),
      .FULL_SLACK (FULL_SLACK)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (fifo_din),
      .dout  (fifo_dout),
      .empty (fifo_empty),
      .full  (fifo_full),
      .count (rd_dat_cnt)
   );

   if (MODE == GB_UP) begin : g_up
      logic [LANE_W-1:0] lane;
      logic              lane_end;
      logic [KEEP_W-1:0] lane_keep;
      logic              pack_vld;
      logic              pack_last;
      logic [KEEP_W-1:0] pack_keep;
      logic [WIDE_W-1:0] pack_dat;
      logic              unused_wr_keep;

      assign unused_wr_keep = ^wr_keep;

      gearbox_lane_ctrl #(.RATIO(RATIO), .LANE_W(LANE_W)) u_lane (
         .clk        (clk),
         .rst        (rst),
         .step       (wr_acc),
         .flush      (last_in),
         .limit_keep ('1),
         .idx        (lane),
         .at_end     (lane_end),
         .keep_upto  (lane_keep)
      );

      // Lane 0 rewrites the whole register so a short packet never carries stale upper lanes.
      always_ff @(posedge clk) begin
         if (rst) begin
            pack_vld  <= 1'b0;
            pack_last <= 1'b0;
            pack_keep <= '0;
            pack_dat  <= '0;
         end else begin
            pack_vld <= wr_acc && (lane_end || last_in);
            if (wr_acc) begin
               if (lane == '0) pack_dat <= WIDE_W'(wr_dat);
               else            pack_dat[int'(lane) * DATA_IN_WIDTH +: DATA_IN_WIDTH] <= wr_dat;
               pack_keep <= lane_keep;
               pack_last <= last_in;
            end
         end
      end

      assign fifo_push = pack_vld;
      assign fifo_din  = {pack_last, pack_keep, pack_dat};
      assign fifo_pop  = rd_ena && !fifo_empty;
      assign rd_dat    = head_dat;
      assign rd_keep   = fifo_empty ? '1 : head_keep;
      assign rd_last   = head_last && !fifo_empty;
   end else if (MODE == GB_DOWN) begin : g_down
      logic [LANE_W-1:0] sel;
      logic              sel_end;
      logic              rd_acc;
      logic [KEEP_W-1:0] unused_keep_upto;

      assign rd_acc = rd_ena && !fifo_empty;

      gearbox_lane_ctrl #(.RATIO(RATIO), .LANE_W(LANE_W)) u_lane (
         .clk        (clk),
         .rst        (rst),
         .step       (rd_acc),
         .flush      (1'b0),
         .limit_keep (head_keep),
         .idx        (sel),
         .at_end     (sel_end),
         .keep_upto  (unused_keep_upto)
      );

      // The head entry is popped only once its highest kept slice has been read.
      assign fifo_push = wr_acc;
      assign fifo_din  = {last_in, wr_keep | KEEP_W'(1), wr_dat};
      assign fifo_pop  = rd_acc && sel_end;
      assign rd_dat    = head_dat[int'(sel) * DATA_OUT_WIDTH +: DATA_OUT_WIDTH];
      assign rd_keep   = '1;
      assign rd_last   = head_last && sel_end && !fifo_empty;
   end else begin : g_equal
      logic unused_keep;

      assign unused_keep = ^{wr_keep, head_keep};
      assign fifo_push   = wr_acc;
      assign fifo_din    = {last_in, 1'b1, wr_dat};
      assign fifo_pop    = rd_ena && !fifo_empty;
      assign rd_dat      = head_dat;
      assign rd_keep     = '1;
      assign rd_last     = head_last && !fifo_empty;
   end

endmodule

// File: doc/simple_fifo_gearbox.md
# simple_fifo_gearbox

First-word-fall-through FIFO with bidirectional power-of-two width conversion, partial-word flush on `wr_last`, lane-keep signalling and a sticky overflow flag. It replaces chained 2:1 packers with one N:1 packer (up-size) or a 1:N unpacker (down-size) around a single wide `simple_fifo`. It sits between narrow sensor/ADC streams and wide memory/DMA paths, in either direction.

## Interface
- `DATA_IN_WIDTH`, 16: write word width.
- `DATA_OUT_WIDTH`, 128: read word width. The ratio to `DATA_IN_WIDTH` is 2^k in either direction, k = 0..5.
- `ADDR_WIDTH`, 8: FIFO depth `DEPTH = 2**ADDR_WIDTH` wide words.
- `FULL_SLACK`, 1: `wr_full` asserts at `DEPTH-FULL_SLACK` entries. Must be ≥1; a value of 0 is an elaboration error.
- `USE_LAST`, 1: 0 ties `rd_last` to 0 and ignores `wr_last`.
- Derived: `RATIO = max(OUT,IN)/min(OUT,IN)`, `KEEP_W = RATIO`, `UP = OUT>IN`, `DOWN = IN>OUT`.
- `clk` in 1: sole clock.
- `rst` in 1: reset, synchronous to `clk`, active-high.
- `wr_ena` in 1: write request.
- `wr_dat` in `DATA_IN_WIDTH`: write data.
- `wr_last` in 1: end of packet.
- `wr_keep` in `KEEP_W`: valid output lanes of `wr_dat`. DOWN mode only; contiguous from bit 0; bit 0 is forced to 1.
- `wr_full` out 1: write backpressure.
- `wr_ovf` out 1: sticky overflow flag; a write was dropped.
- `rd_ena` in 1: pop or advance.
- `rd_dat` out `DATA_OUT_WIDTH`: head data, valid while `!rd_empty`.
- `rd_keep` out `KEEP_W`: valid input lanes in `rd_dat`. UP mode only; all-ones otherwise.
- `rd_last` out 1: head is the final output of a packet; gated to 0 when empty.
- `rd_empty` out 1: no data at head.
- `rd_dat_cnt` out `ADDR_WIDTH+1`: wide entries stored in the FIFO.

## Operation
- **Accept and drop rules**
  - A write is accepted when `wr_ena && !wr_full`.
  - `wr_ena && wr_full` drops the write and sets `wr_ovf`.
  - A read is accepted when `rd_ena && !rd_empty`. `rd_ena` while empty is ignored.
- **UP mode (packer)**
  - Lane index `lane` runs 0..RATIO-1. Accepted word i is placed in lane i, with the first word in the LSBs.
  - A push to the FIFO happens on lane RATIO-1, or on `wr_last` at any lane.
  - The pushed word carries `keep = (2<<lane)-1` and `last = wr_last`. Unwritten lanes are zero. `lane` then returns to 0.
- **DOWN mode (unpacker)**
  - Each accepted wide word is stored with its `wr_keep` and `wr_last`.
  - `rd_dat` is slice `sel` of the head entry; `sel` resets to 0.
  - On a read: if `sel` is the highest kept lane, pop the head and set `sel=0`; else `sel+1`.
  - `rd_last` = head.last && `sel` is the highest kept lane.
- **EQUAL mode:** plain FWFT FIFO.
- `wr_full = rd_dat_cnt >= DEPTH-FULL_SLACK`. With `FULL_SLACK ≥ 1`, the registered packer push can never overflow the FIFO.
- `rd_dat_cnt` counts wide entries only. It excludes the packer partial and the unpacker's consumed slices.
- **Simultaneous events**
  - A FIFO push and pop in the same cycle leave the count unchanged.
  - `wr_last` on lane RATIO-1 gives one push with full keep.
- **Reset (`rst`)**, including mid-packet:
  - Discards the packer partial and FIFO contents.
  - `lane=0`, `sel=0`.
  - Reset values: `rd_empty=1`, `wr_full=0`, `wr_ovf=0`, `rd_last=0`, `rd_dat_cnt=0`, `rd_keep` all-ones.

## Timing
- **UP latency:** the accept that completes a word is at cycle t. The packer register pushes at t+1, and `rd_empty` falls at t+2.
- **DOWN/EQUAL latency:** accept at t, and `rd_empty` falls at t+1.
- **Throughput**
  - UP: 1 input/cycle.
  - DOWN: 1 output slice/cycle. Input throughput is limited to 1 wide word per kept-lane-count cycles through backpressure.
- **Flag timing**
  - `wr_full`, `rd_empty` and `rd_dat_cnt` update in the cycle after a push or pop.
  - `wr_ovf` rises in the cycle after the dropped write.
- `rd_dat`, `rd_keep` and `rd_last` are stable while `!rd_empty && !rd_ena`.

## Structure
- Shared package `gearbox_pkg`:
  - `clog2`-based `RATIO`/`KEEP_W` functions.
  - Mode enum `{GB_EQUAL, GB_UP, GB_DOWN}`.
  - Keep-to-highest-lane function.
- Storage is `simple_fifo` at width `max(IN,OUT)+KEEP_W+1`, holding data, keep and last.
- One natural sub-module, `gearbox_lane_ctrl`. It holds the lane/sel counter and keep logic, instantiated on the write side (UP) or the read side (DOWN).

## Test plan
- **UP full word:** IN=16, OUT=64. Write 0x1111, 0x2222, 0x3333, 0x4444 on cycles 0–3 → at cycle 5, `rd_dat=0x4444_3333_2222_1111`, `rd_keep=4'hF`, `rd_last=0`.
- **UP flush:** write 0xAAAA, then 0xBBBB with `wr_last=1` → `rd_dat=0x0000_0000_BBBB_AAAA`, `rd_keep=4'h3`, `rd_last=1`; `lane` returns to 0.
- **DOWN partial keep:** IN=64, OUT=16. Write 0xDDDD_CCCC_BBBB_AAAA with `wr_keep=4'h7`, `wr_last=1`; hold `rd_ena` high.
  - Outputs are AAAA, BBBB, CCCC; `rd_last` is high only on CCCC.
  - `rd_empty` is high after the third read.
- **Full/overflow:** ADDR_WIDTH=2, FULL_SLACK=1, EQUAL mode, no reads. Write 5 words.
  - `wr_full` rises at count 3.
  - The 4th and 5th writes are dropped; `wr_ovf=1`; `rd_dat_cnt=3`.
- **Simultaneous push/pop at count 2** → the count stays at 2, and the read data order is preserved.
- **Reset mid-packet:** UP mode, 2 lanes written, then `rst` for 1 cycle.
  - All outputs return to their reset values.
  - The next 4 writes form a clean word with no stale lanes.
